// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - multi-slot vending controller with credit, per-slot stock and change payout
//
// Purpose: accepts half-dollar / one-dollar coins into a bounded credit register,
// vends from one of SLOTS stocked slots, pays change or refunds one half-dollar
// per cycle.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   one_dollar            coin strobe, 2 units
//   half_dollar           coin strobe, 1 unit
//   sel_valid, sel_slot   selection request and requested slot
//   cancel                refund request
//   restock, restock_slot refill strobe and slot to refill
//   dispense              vend pulse (state VEND)
//   dispense_slot         slot being vended
//   half_out              one half-dollar of change/refund per high cycle
//   collect               transaction-complete pulse after a vend
//   coin_return           rejected-coin pulse (registered)
//   sel_err               rejected-selection pulse (registered)
//   credit                current credit in half-dollar units
//   busy                  high outside ACCEPT
//   sold_out              bit i high when slot i is empty
module vend_ctrl #(
  parameter int PRICE      = 5,
  parameter int MAX_CREDIT = 8,
  parameter int SLOTS      = 4,
  parameter int STOCK_MAX  = 3,
  localparam int SW  = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int STW = $clog2(STOCK_MAX + 1),
  localparam int CW  = $clog2(MAX_CREDIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             one_dollar,
  input  logic             half_dollar,
  input  logic             sel_valid,
  input  logic [SW-1:0]    sel_slot,
  input  logic             cancel,
  input  logic             restock,
  input  logic [SW-1:0]    restock_slot,
  output logic             dispense,
  output logic [SW-1:0]    dispense_slot,
  output logic             half_out,
  output logic             collect,
  output logic             coin_return,
  output logic             sel_err,
  output logic [CW-1:0]    credit,
  output logic             busy,
  output logic [SLOTS-1:0] sold_out
);

  typedef enum logic [2:0] {
    S_ACCEPT = 3'd0,
    S_VEND   = 3'd1,
    S_CHANGE = 3'd2,
    S_DONE   = 3'd3,
    S_REFUND = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [SW-1:0]   disp_slot_q, disp_slot_d;
  logic            coin_return_q, coin_return_d;
  logic            sel_err_q, sel_err_d;
  logic [STW-1:0]  stock_q [SLOTS];
  logic [STW-1:0]  stock_d [SLOTS];

  // Combinational helpers
  logic            coin_any;
  logic [CW:0]     coin_sum;     // one extra bit so overflow past MAX_CREDIT is visible
  logic            sel_in_stock;
  logic            cancel_acc;
  logic            sel_acc;

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_slot_d   = disp_slot_q;
    stock_d       = stock_q;
    coin_return_d = 1'b0;
    sel_err_d     = 1'b0;
    cancel_acc    = 1'b0;
    sel_acc       = 1'b0;
    sel_in_stock  = 1'b0;

    coin_any = one_dollar | half_dollar;
    coin_sum = {1'b0, credit_q} + (CW+1)'({one_dollar, half_dollar});

    // Matching against each real slot index also rejects out-of-range requests
    for (int i = 0; i < SLOTS; i++) begin
      if (sel_slot == SW'(i) && stock_q[i] != '0) sel_in_stock = 1'b1;
    end

    case (state_q)
      S_ACCEPT: begin
        if (cancel && credit_q != '0) begin
          cancel_acc = 1'b1;
          state_d    = S_REFUND;
        end else if (sel_valid) begin
          if (sel_in_stock && credit_q >= CW'(PRICE)) begin
            sel_acc     = 1'b1;
            state_d     = S_VEND;
            disp_slot_d = sel_slot;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      S_VEND: begin
        credit_d = credit_q - CW'(PRICE);
        for (int i = 0; i < SLOTS; i++) begin
          if (disp_slot_q == SW'(i) && stock_q[i] != '0) stock_d[i] = stock_q[i] - STW'(1);
        end
        state_d = (credit_q != CW'(PRICE)) ? S_CHANGE : S_DONE;
      end
      S_CHANGE: begin
        credit_d = (credit_q != '0) ? credit_q - CW'(1) : '0;
        if (credit_q <= CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_ACCEPT;
      end
      S_REFUND: begin
        credit_d = (credit_q != '0) ? credit_q - CW'(1) : '0;
        if (credit_q <= CW'(1)) state_d = S_ACCEPT;
      end
      default: begin
        state_d = S_ACCEPT;
      end
    endcase

    // Coins land only when nothing else claimed the cycle; any strobe otherwise bounces
    if (coin_any) begin
      if (state_q == S_ACCEPT && !cancel_acc && !sel_acc &&
          coin_sum <= (CW+1)'(MAX_CREDIT)) begin
        credit_d = coin_sum[CW-1:0];
      end else begin
        coin_return_d = 1'b1;
      end
    end

    // Restock is applied last so it overrides a same-cycle vend decrement
    if (restock) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (restock_slot == SW'(i)) stock_d[i] = STW'(STOCK_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_ACCEPT;
      credit_q      <= '0;
      disp_slot_q   <= '0;
      coin_return_q <= 1'b0;
      sel_err_q     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) stock_q[i] <= STW'(STOCK_MAX);
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_slot_q   <= disp_slot_d;
      coin_return_q <= coin_return_d;
      sel_err_q     <= sel_err_d;
      stock_q       <= stock_d;
    end
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) sold_out[i] = (stock_q[i] == '0);
  end

  assign dispense      = (state_q == S_VEND);
  assign half_out      = (state_q == S_CHANGE) || (state_q == S_REFUND);
  assign collect       = (state_q == S_DONE);
  assign busy          = (state_q != S_ACCEPT);
  assign dispense_slot = disp_slot_q;
  assign credit        = credit_q;
  assign coin_return   = coin_return_q;
  assign sel_err       = sel_err_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - bench for vend_ctrl with table-driven vectors and a scoreboard queue
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_dollar = 1'b0, half_dollar = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_slot = 2'd0;
  logic       cancel = 1'b0, restock = 1'b0;
  logic [1:0] restock_slot = 2'd0;
  logic       dispense, half_out, collect, coin_return, sel_err, busy;
  logic [1:0] dispense_slot;
  logic [3:0] credit;
  logic [3:0] sold_out;

  vend_ctrl dut (
    .clk(clk), .reset(reset),
    .one_dollar(one_dollar), .half_dollar(half_dollar),
    .sel_valid(sel_valid), .sel_slot(sel_slot),
    .cancel(cancel), .restock(restock), .restock_slot(restock_slot),
    .dispense(dispense), .dispense_slot(dispense_slot),
    .half_out(half_out), .collect(collect),
    .coin_return(coin_return), .sel_err(sel_err),
    .credit(credit), .busy(busy), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        one, half, sv;
    bit [1:0]  ss;
    bit        cn, rs;
    bit [1:0]  rsl;
    bit [15:0] exp;
  } vec_t;

  typedef struct {
    int        idx;
    bit [15:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // {dispense, dispense_slot (masked by dispense), half_out, collect, coin_return, sel_err, busy, credit, sold_out}
  function automatic logic [15:0] outs();
    return {dispense, (dispense ? dispense_slot : 2'b00), half_out, collect,
            coin_return, sel_err, busy, credit, sold_out};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit one, half, sv, input bit [1:0] ss, input bit cn, rs,
                     input bit [1:0] rsl, input bit dsp, input bit [1:0] dsl,
                     input bit ho, co, cr, se, bz, input bit [3:0] cred, so);
    vec_t v;
    v.one = one; v.half = half; v.sv = sv; v.ss = ss;
    v.cn = cn; v.rs = rs; v.rsl = rsl;
    v.exp = {dsp, dsl, ho, co, cr, se, bz, cred, so};
    vecs.push_back(v);
  endtask

  task automatic idle(input bit ho, co, bz, input bit [3:0] cred, so);
    add(0,0,0,2'd0,0,0,2'd0, 0,2'd0,ho,co,0,0,bz,cred,so);
  endtask

  task automatic coin(input bit one, half, cr, input bit [3:0] cred, so);
    add(one,half,0,2'd0,0,0,2'd0, 0,2'd0,0,0,cr,0,0,cred,so);
  endtask

  task automatic sel(input bit [1:0] slot, input bit [3:0] cred, so);
    add(0,0,1,slot,0,0,2'd0, 1,slot,0,0,0,0,1,cred,so);
  endtask

  task automatic coins5(input bit [3:0] so);
    coin(1,0,0,4'd2,so); coin(1,0,0,4'd4,so); coin(0,1,0,4'd5,so);
  endtask

  // Exact-price vend: dispense, then collect, then idle
  task automatic vsel(input bit [1:0] slot, input bit [3:0] so_b, so_a);
    sel(slot, 4'd5, so_b);
    idle(0,1,1,4'd0,so_a);
    idle(0,0,0,4'd0,so_a);
  endtask

  task automatic vend5(input bit [1:0] slot, input bit [3:0] so_b, so_a);
    coins5(so_b);
    vsel(slot, so_b, so_a);
  endtask

  // Scoreboard consumer: compares one row per cycle, just after the edge that produced it
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check($sformatf("row%0d", e.idx), outs(), e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // A: exact-price vend of slot 2; a coin alongside the accepted select bounces
    coins5(4'h0);
    add(0,1,1,2'd2,0,0,2'd0, 1,2'd2,0,0,1,0,1,4'd5,4'h0);
    idle(0,1,1,4'd0,4'h0);
    idle(0,0,0,4'd0,4'h0);
    // B: credit 8, vend slot 0, three change cycles
    coin(1,0,0,4'd2,4'h0); coin(1,0,0,4'd4,4'h0); coin(1,0,0,4'd6,4'h0); coin(1,0,0,4'd8,4'h0);
    sel(2'd0, 4'd8, 4'h0);
    idle(1,0,1,4'd3,4'h0); idle(1,0,1,4'd2,4'h0); idle(1,0,1,4'd1,4'h0);
    idle(0,1,1,4'd0,4'h0);
    idle(0,0,0,4'd0,4'h0);
    // C: overflow rejection at 7 and 8, then a coin while paying change
    coin(1,0,0,4'd2,4'h0); coin(1,0,0,4'd4,4'h0); coin(1,0,0,4'd6,4'h0);
    coin(0,1,0,4'd7,4'h0);
    coin(1,1,1,4'd7,4'h0);
    coin(0,1,0,4'd8,4'h0);
    coin(0,1,1,4'd8,4'h0);
    sel(2'd1, 4'd8, 4'h0);
    idle(1,0,1,4'd3,4'h0);
    add(0,1,0,2'd0,0,0,2'd0, 0,2'd0,1,0,1,0,1,4'd2,4'h0);
    idle(1,0,1,4'd1,4'h0);
    idle(0,1,1,4'd0,4'h0);
    idle(0,0,0,4'd0,4'h0);
    // D: cancel at zero credit does nothing; underfunded select; refund of 6
    add(0,0,0,2'd0,1,0,2'd0, 0,2'd0,0,0,0,0,0,4'd0,4'h0);
    coin(1,0,0,4'd2,4'h0); coin(1,0,0,4'd4,4'h0);
    add(0,0,1,2'd1,0,0,2'd0, 0,2'd0,0,0,0,1,0,4'd4,4'h0);
    coin(0,1,0,4'd5,4'h0); coin(0,1,0,4'd6,4'h0);
    add(0,0,0,2'd0,1,0,2'd0, 0,2'd0,1,0,0,0,1,4'd6,4'h0);
    for (int c = 5; c >= 1; c--) idle(1,0,1,4'(c),4'h0);
    idle(0,0,0,4'd0,4'h0);
    // E: empty slot 1, then a select on it is refused and slot 3 vends instead
    vend5(2'd1, 4'h0, 4'h0);
    vend5(2'd1, 4'h0, 4'h2);
    coins5(4'h2);
    add(0,0,1,2'd1,0,0,2'd0, 0,2'd0,0,0,0,1,0,4'd5,4'h2);
    vsel(2'd3, 4'h2, 4'h2);
    // F: restock slot 1, then restock again in the VEND cycle of slot 1; three more vends empty it
    add(0,0,0,2'd0,0,1,2'd1, 0,2'd0,0,0,0,0,0,4'd0,4'h0);
    coins5(4'h0);
    sel(2'd1, 4'd5, 4'h0);
    add(0,0,0,2'd0,0,1,2'd1, 0,2'd0,0,1,0,0,1,4'd0,4'h0);
    idle(0,0,0,4'd0,4'h0);
    vend5(2'd1, 4'h0, 4'h0);
    vend5(2'd1, 4'h0, 4'h0);
    vend5(2'd1, 4'h0, 4'h2);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 16'h0000);
    check("reset_dslot", {14'd0, dispense_slot}, 16'h0000);
    reset = 1'b1;

    // Table pass: driver pushes the expectation as it drives each row
    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      @(negedge clk);
      one_dollar = vecs[i].one; half_dollar = vecs[i].half;
      sel_valid = vecs[i].sv; sel_slot = vecs[i].ss;
      cancel = vecs[i].cn; restock = vecs[i].rs; restock_slot = vecs[i].rsl;
      e.idx = i; e.exp = vecs[i].exp;
      sb.push_back(e);
    end
    @(negedge clk);
    one_dollar = 0; half_dollar = 0; sel_valid = 0; cancel = 0; restock = 0;
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'd0);

    // Reset in the middle of paying change; slot 1 is empty beforehand
    for (int k = 0; k < 4; k++) begin
      one_dollar = 1; @(negedge clk);
    end
    one_dollar = 0; sel_valid = 1; sel_slot = 2'd2;
    @(negedge clk);
    sel_valid = 0;
    @(negedge clk);
    check("pre_reset_change", outs(), {1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,1'b1,4'd3,4'h2});
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outs", outs(), 16'h0000);
    check("midreset_dslot", {14'd0, dispense_slot}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", outs(), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Parametrised multi-slot vending controller and the successor to the single-product coin FSM. It accepts half-dollar and one-dollar coins into a bounded credit register and serves a selection from one of SLOTS product slots, each with its own stock counter. After a vend it pays back change one half-dollar per cycle, and a cancel refunds the full credit the same way. It sits between the coin-acceptor/keypad front end and the dispense and change actuators.

## Interface
- PRICE, 5: vend price in half-dollar units; 1 ≤ PRICE ≤ MAX_CREDIT
- MAX_CREDIT, 8: credit ceiling in half-dollar units
- SLOTS, 4: number of product slots; SW = max(1, $clog2(SLOTS))
- STOCK_MAX, 3: per-slot capacity, reset/restock value; STW = $clog2(STOCK_MAX+1)
- CW: derived, $clog2(MAX_CREDIT+1)

Ports:
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- one_dollar  in  1  coin strobe worth 2 units, one cycle per coin
- half_dollar  in  1  coin strobe worth 1 unit
- sel_valid  in  1  selection request
- sel_slot  in  SW  requested slot
- cancel  in  1  refund request
- restock  in  1  refill strobe
- restock_slot  in  SW  slot to refill
- dispense  out  1  vend pulse
- dispense_slot  out  SW  slot being vended; valid while dispense=1
- half_out  out  1  one half-dollar of change or refund per high cycle
- collect  out  1  transaction-complete pulse after a vend
- coin_return  out  1  rejected-coin pulse
- sel_err  out  1  rejected-selection pulse
- credit  out  CW  current credit
- busy  out  1  high in any state other than ACCEPT
- sold_out  out  SLOTS  bit i high when stock[i]==0

## Operation
- States: ACCEPT, VEND, CHANGE, DONE, REFUND. dispense, half_out and collect are Moore outputs: dispense=VEND; half_out=CHANGE|REFUND; collect=DONE.
- Priority in ACCEPT: cancel > sel_valid > coins.
- Cancel:
  - With credit>0, goes to REFUND.
  - With credit==0, no effect.
- Selection:
  - Accepted when sel_slot<SLOTS, stock[sel_slot]>0 and credit≥PRICE. Latches dispense_slot and goes to VEND.
  - Otherwise sel_err pulses and the state is unchanged.
- Coins:
  - value = 2·one_dollar + half_dollar; both strobes in one cycle give value 3.
  - Accepted only in ACCEPT, with no accepted cancel or selection in the same cycle, and credit+value ≤ MAX_CREDIT.
  - Otherwise every strobe in that cycle is rejected as a whole and coin_return pulses.
- VEND, one cycle:
  - credit −= PRICE and stock[dispense_slot] −= 1.
  - Next state is CHANGE if the remaining credit is >0, else DONE.
- CHANGE: credit −= 1 each cycle; goes to DONE in the cycle credit reaches 0.
- DONE: one cycle, then ACCEPT.
- REFUND: credit −= 1 each cycle; goes to ACCEPT (no collect) when credit reaches 0.
- Restock:
  - Accepted in any state: stock[restock_slot] ← STOCK_MAX.
  - Ignored if restock_slot ≥ SLOTS.
  - Wins over a same-cycle VEND decrement on the same slot.
- Arithmetic is unsigned. credit never exceeds MAX_CREDIT and never underflows.

## Timing
- Reset values:
  - state=ACCEPT, credit=0, every stock=STOCK_MAX.
  - dispense, half_out, collect, coin_return, sel_err, busy, dispense_slot all 0; sold_out all 0.
- Reset asserted mid-transaction clears everything immediately. Credit is forfeited.
- Coin sampled at edge N: credit updated after edge N.
- Selection accepted at edge N:
  - dispense high in cycle N+1.
  - half_out high for cycles N+2 … N+1+(C−PRICE), where C is the credit at selection.
  - collect high one cycle after that.
- coin_return and sel_err are registered: high for exactly the cycle after the offending input.
- busy is asserted from the cycle after an accepted selection or cancel until the state returns to ACCEPT. Coins during busy are rejected.
- Total half_out pulses:
  - vend: C−PRICE
  - refund: C

## Test plan
- Reset, insert 1+1+0.5 dollars (credit 5), select slot 2 → dispense for 1 cycle with dispense_slot=2, no half_out, collect next cycle, credit=0, stock[2]=2.
- Credit 8, select slot 0 → dispense, then 3 consecutive half_out cycles, then collect; busy high throughout; credit=0.
- Credit 7, one_dollar plus half_dollar in the same cycle → coin_return the next cycle, credit stays 7. Then half_dollar → credit 8.
- Credit 4, select → sel_err, credit 4 unchanged. Credit 6, cancel → 6 half_out cycles, no collect, credit=0.
- Vend slot 1 three times → sold_out[1]=1 and a 4th select gives sel_err. Restock slot 1 in the same cycle as a vend of slot 1 → stock[1]=3.
- Reset pulsed during CHANGE → outputs 0 immediately, credit=0, state ACCEPT, all stock=3.
